// File: rtl/opennic_stage_pkg.sv
// Shared definitions for the stage control space: register offsets, AXI-Lite
// response codes, FSM state types and the address decoder.
package opennic_stage_pkg;

  localparam int CNT_WIDTH = 32;

  localparam logic [12:0] ADDR_VERSION = 13'h0000;
  localparam logic [12:0] ADDR_SCRATCH = 13'h0004;
  localparam logic [12:0] ADDR_CTRL    = 13'h1000;
  localparam logic [12:0] ADDR_RX_CNT  = 13'h1008;
  localparam logic [12:0] ADDR_TX_CNT  = 13'h100C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic { WR_IDLE, WR_RESP } wr_state_e;
  typedef enum logic { RD_IDLE, RD_DATA } rd_state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_VERSION,
    SEL_SCRATCH,
    SEL_CTRL,
    SEL_RX_CNT,
    SEL_TX_CNT
  } reg_sel_e;

  // word is addr[12:2]; any set bit above bit 12 makes the access unmapped
  function automatic reg_sel_e decode_addr(input logic [10:0] word, input logic hi_zero);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (hi_zero) begin
      if      (word == ADDR_VERSION[12:2]) sel = SEL_VERSION;
      else if (word == ADDR_SCRATCH[12:2]) sel = SEL_SCRATCH;
      else if (word == ADDR_CTRL[12:2])    sel = SEL_CTRL;
      else if (word == ADDR_RX_CNT[12:2])  sel = SEL_RX_CNT;
      else if (word == ADDR_TX_CNT[12:2])  sel = SEL_TX_CNT;
    end
    return sel;
  endfunction

endpackage

// File: rtl/opennic_stage_axil_regs_if.sv
// AXI4-Lite bus between the shell (master) and the stage register block (slave).
// Every channel transfers on a clock edge where valid and ready are both high;
// a source holds valid and its payload stable until that edge.
interface opennic_stage_axil_regs_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  awvalid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awready;
  logic                  wvalid;
  logic [31:0]           wdata;
  logic                  wready;
  logic                  bvalid;
  logic [1:0]            bresp;
  logic                  bready;
  logic                  arvalid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arready;
  logic                  rvalid;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/stage_evt_counter.sv
// Free-running packet event counter; wraps at all-ones and a clear beats a
// simultaneous event.
module stage_evt_counter
  import opennic_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 evt,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (evt) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/opennic_stage_axil_regs.sv
// AXI4-Lite register block for the user-box stage: version, scratch, control
// (stage enable, counter clear) and RX/TX packet counters.
module opennic_stage_axil_regs
  import opennic_stage_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic      axil_aclk,
  input  logic      axil_aresetn,
  opennic_stage_axil_regs_if.slave s_axil,
  input  logic      rx_pkt_evt,
  input  logic      tx_pkt_evt,
  output logic      stage_enable,
  output wr_state_e dbg_wr_state,
  output rd_state_e dbg_rd_state
);

  wr_state_e wr_state, wr_next;
  rd_state_e rd_state, rd_next;

  logic        ready_en;
  logic        aw_held, w_held;
  reg_sel_e    aw_sel_q;
  logic [31:0] w_data_q;
  logic [1:0]  bresp_q;
  logic [31:0] scratch_q;
  logic        ctrl_en_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [CNT_WIDTH-1:0] rx_cnt, tx_cnt;

  logic        awready, wready, arready;
  logic        aw_hs, w_hs, ar_hs;
  logic        do_write, cnt_clr;
  reg_sel_e    aw_sel_in, cur_aw_sel, ar_sel;
  logic [31:0] cur_wdata;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axil.awaddr[1:0], s_axil.araddr[1:0]};

  assign aw_sel_in = decode_addr(s_axil.awaddr[12:2], ~|s_axil.awaddr[ADDR_WIDTH-1:13]);
  assign ar_sel    = decode_addr(s_axil.araddr[12:2], ~|s_axil.araddr[ADDR_WIDTH-1:13]);

  assign aw_hs = s_axil.awvalid & awready;
  assign w_hs  = s_axil.wvalid & wready;
  assign ar_hs = s_axil.arvalid & arready;

  // A beat arriving this cycle counts as held, so AW+W together commit at once
  assign cur_aw_sel = aw_held ? aw_sel_q : aw_sel_in;
  assign cur_wdata  = w_held ? w_data_q : s_axil.wdata;
  assign do_write   = (wr_state == WR_IDLE) && (aw_held | aw_hs) && (w_held | w_hs);
  assign cnt_clr    = do_write && (cur_aw_sel == SEL_CTRL) && cur_wdata[1];

  always_comb begin
    wr_next = wr_state;
    awready = ready_en && (wr_state == WR_IDLE) && !aw_held;
    wready  = ready_en && (wr_state == WR_IDLE) && !w_held;
    case (wr_state)
      WR_IDLE: if (do_write) wr_next = WR_RESP;
      WR_RESP: if (s_axil.bready) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge axil_aclk) begin
    if (!axil_aresetn) begin
      wr_state  <= WR_IDLE;
      ready_en  <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_sel_q  <= SEL_NONE;
      w_data_q  <= '0;
      bresp_q   <= RESP_OKAY;
      scratch_q <= '0;
      ctrl_en_q <= 1'b0;
    end else begin
      wr_state <= wr_next;
      ready_en <= 1'b1;
      if (do_write) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= (cur_aw_sel == SEL_NONE) ? RESP_DECERR : RESP_OKAY;
        if (cur_aw_sel == SEL_SCRATCH) scratch_q <= cur_wdata;
        if (cur_aw_sel == SEL_CTRL)    ctrl_en_q <= cur_wdata[0];
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_sel_q <= aw_sel_in;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axil.wdata;
        end
      end
    end
  end

  // Read data comes from registered state, so same-cycle writes/increments are not yet visible
  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (ar_sel)
      SEL_VERSION: rd_word = VERSION;
      SEL_SCRATCH: rd_word = scratch_q;
      SEL_CTRL:    rd_word = {31'b0, ctrl_en_q};
      SEL_RX_CNT:  rd_word = rx_cnt;
      SEL_TX_CNT:  rd_word = tx_cnt;
      default:     rd_resp = RESP_DECERR;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    arready = ready_en && (rd_state == RD_IDLE);
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_DATA;
      RD_DATA: if (s_axil.rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge axil_aclk) begin
    if (!axil_aresetn) begin
      rd_state <= RD_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        rdata_q <= rd_word;
        rresp_q <= rd_resp;
      end
    end
  end

  stage_evt_counter u_rx_cnt (
    .clk   (axil_aclk),
    .rst_n (axil_aresetn),
    .clr   (cnt_clr),
    .evt   (rx_pkt_evt),
    .count (rx_cnt)
  );

  stage_evt_counter u_tx_cnt (
    .clk   (axil_aclk),
    .rst_n (axil_aresetn),
    .clr   (cnt_clr),
    .evt   (tx_pkt_evt),
    .count (tx_cnt)
  );

  assign s_axil.awready = awready;
  assign s_axil.wready  = wready;
  assign s_axil.bvalid  = (wr_state == WR_RESP);
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = arready;
  assign s_axil.rvalid  = (rd_state == RD_DATA);
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;

  assign stage_enable = ctrl_en_q;
  assign dbg_wr_state = wr_state;
  assign dbg_rd_state = rd_state;

endmodule

// File: tb/tb_opennic_stage_axil_regs.sv
// Directed bench for opennic_stage_axil_regs: channel ordering, back-pressure,
// decode errors, counters with clear/wrap, and reset during a transaction.
module tb_opennic_stage_axil_regs;
  import opennic_stage_pkg::*;

  localparam int LIMIT = 50;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_pkt_evt, tx_pkt_evt;
  logic stage_enable;
  wr_state_e dbg_wr_state;
  rd_state_e dbg_rd_state;

  int checks = 0;
  int errors = 0;

  opennic_stage_axil_regs_if #(.ADDR_WIDTH(32)) axil ();

  opennic_stage_axil_regs #(
    .ADDR_WIDTH (32),
    .VERSION    (32'h0001_0000)
  ) dut (
    .axil_aclk    (clk),
    .axil_aresetn (rst_n),
    .s_axil       (axil),
    .rx_pkt_evt   (rx_pkt_evt),
    .tx_pkt_evt   (tx_pkt_evt),
    .stage_enable (stage_enable),
    .dbg_wr_state (dbg_wr_state),
    .dbg_rd_state (dbg_rd_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    axil.awvalid = 1'b0; axil.awaddr = '0;
    axil.wvalid  = 1'b0; axil.wdata  = '0;
    axil.bready  = 1'b0;
    axil.arvalid = 1'b0; axil.araddr = '0;
    axil.rready  = 1'b0;
    rx_pkt_evt   = 1'b0; tx_pkt_evt  = 1'b0;
  endtask

  // driver tasks: entered and left on a falling edge
  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    axil.awvalid = 1'b1; axil.awaddr = a;
    while (!axil.awready && n < LIMIT) begin @(negedge clk); n++; end
    check("aw_handshake_bound", 32'(n < LIMIT), 32'd1);
    @(negedge clk);
    axil.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d);
    int n = 0;
    axil.wvalid = 1'b1; axil.wdata = d;
    while (!axil.wready && n < LIMIT) begin @(negedge clk); n++; end
    check("w_handshake_bound", 32'(n < LIMIT), 32'd1);
    @(negedge clk);
    axil.wvalid = 1'b0;
  endtask

  task automatic recv_b(input string tag, input logic [1:0] exp_resp);
    int n = 0;
    while (!axil.bvalid && n < LIMIT) begin @(negedge clk); n++; end
    check({tag, "_bvalid_bound"}, 32'(n < LIMIT), 32'd1);
    check({tag, "_bresp"}, 32'(axil.bresp), 32'(exp_resp));
    axil.bready = 1'b1;
    @(negedge clk);
    axil.bready = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    axil.arvalid = 1'b1; axil.araddr = a;
    while (!axil.arready && n < LIMIT) begin @(negedge clk); n++; end
    check("ar_handshake_bound", 32'(n < LIMIT), 32'd1);
    @(negedge clk);
    axil.arvalid = 1'b0;
  endtask

  task automatic recv_r(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int n = 0;
    while (!axil.rvalid && n < LIMIT) begin @(negedge clk); n++; end
    check({tag, "_rvalid_bound"}, 32'(n < LIMIT), 32'd1);
    check({tag, "_rdata"}, axil.rdata, exp_data);
    check({tag, "_rresp"}, 32'(axil.rresp), 32'(exp_resp));
    axil.rready = 1'b1;
    @(negedge clk);
    axil.rready = 1'b0;
  endtask

  task automatic read(input string tag, input logic [31:0] a, input logic [31:0] exp_data,
                      input logic [1:0] exp_resp);
    send_ar(a);
    recv_r(tag, exp_data, exp_resp);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_awready", 32'(axil.awready), 32'd0);
    check("rst_wready", 32'(axil.wready), 32'd0);
    check("rst_arready", 32'(axil.arready), 32'd0);
    check("rst_bvalid", 32'(axil.bvalid), 32'd0);
    check("rst_rvalid", 32'(axil.rvalid), 32'd0);
    check("rst_rdata", axil.rdata, 32'd0);
    check("rst_enable", 32'(stage_enable), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_awready", 32'(axil.awready), 32'd1);
    check("post_rst_arready", 32'(axil.arready), 32'd1);

    // 1: AW and W together, CTRL <= 1
    fork
      send_aw(32'h0000_1000);
      send_w(32'h0000_0001);
    join
    check("t1_bvalid_next_cycle", 32'(axil.bvalid), 32'd1);
    check("t1_enable_with_bvalid", 32'(stage_enable), 32'd1);
    recv_b("t1", RESP_OKAY);
    read("t1_ctrl", 32'h0000_1000, 32'h0000_0001, RESP_OKAY);

    // 2: AW first, W three cycles later, bready held low
    send_aw(32'h0000_0004);
    check("t2_awready_dropped", 32'(axil.awready), 32'd0);
    check("t2_wready_still_high", 32'(axil.wready), 32'd1);
    repeat (2) @(negedge clk);
    send_w(32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      check("t2_bvalid_hold", 32'(axil.bvalid), 32'd1);
      check("t2_bresp_hold", 32'(axil.bresp), 32'(RESP_OKAY));
      @(negedge clk);
    end
    recv_b("t2", RESP_OKAY);
    read("t2_scratch", 32'h0000_0004, 32'hDEAD_BEEF, RESP_OKAY);

    // 3: W before AW to an unmapped address
    send_w(32'h1234_5678);
    check("t3_wready_dropped", 32'(axil.wready), 32'd0);
    repeat (2) @(negedge clk);
    send_aw(32'h0000_2000);
    recv_b("t3_unmapped", RESP_DECERR);
    read("t3_unmapped", 32'h0000_2000, 32'h0000_0000, RESP_DECERR);
    read("t3_scratch_kept", 32'h0000_0004, 32'hDEAD_BEEF, RESP_OKAY);
    read("t3_ctrl_kept", 32'h0000_1000, 32'h0000_0001, RESP_OKAY);

    // RO write: OKAY but no effect
    fork
      send_aw(32'h0000_0000);
      send_w(32'hFFFF_FFFF);
    join
    recv_b("ro_write", RESP_OKAY);
    read("ro_version", 32'h0000_0000, 32'h0001_0000, RESP_OKAY);

    // 4: counters, then clear racing an RX event
    for (int i = 0; i < 10; i++) begin
      rx_pkt_evt = 1'b1;
      tx_pkt_evt = (i < 7);
      @(negedge clk);
    end
    rx_pkt_evt = 1'b0; tx_pkt_evt = 1'b0;
    read("t4_rx10", 32'h0000_1008, 32'd10, RESP_OKAY);
    read("t4_tx7", 32'h0000_100C, 32'd7, RESP_OKAY);
    rx_pkt_evt = 1'b1;
    fork
      send_aw(32'h0000_1000);
      send_w(32'h0000_0003);
    join
    rx_pkt_evt = 1'b0;
    recv_b("t4_clr", RESP_OKAY);
    check("t4_enable", 32'(stage_enable), 32'd1);
    read("t4_rx_cleared", 32'h0000_1008, 32'd0, RESP_OKAY);
    read("t4_tx_cleared", 32'h0000_100C, 32'd0, RESP_OKAY);
    read("t4_ctrl_selfclr", 32'h0000_1000, 32'h0000_0001, RESP_OKAY);

    // 5: wrap, read during increment, read during in-flight write
    force dut.u_rx_cnt.count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.u_rx_cnt.count;
    read("t5_rx_max", 32'h0000_1008, 32'hFFFF_FFFF, RESP_OKAY);
    rx_pkt_evt = 1'b1;
    @(negedge clk);
    rx_pkt_evt = 1'b0;
    read("t5_rx_wrap", 32'h0000_1008, 32'd0, RESP_OKAY);

    axil.arvalid = 1'b1; axil.araddr = 32'h0000_1008; rx_pkt_evt = 1'b1;
    @(negedge clk);
    axil.arvalid = 1'b0; rx_pkt_evt = 1'b0;
    recv_r("t5_pre_incr", 32'd0, RESP_OKAY);
    read("t5_post_incr", 32'h0000_1008, 32'd1, RESP_OKAY);

    send_aw(32'h0000_0004);
    read("t5_version_inflight", 32'h0000_0000, 32'h0001_0000, RESP_OKAY);
    send_w(32'hCAFE_0001);
    recv_b("t5_inflight", RESP_OKAY);
    read("t5_scratch", 32'h0000_0004, 32'hCAFE_0001, RESP_OKAY);

    // read CTRL in the cycle a CTRL write commits -> old value
    axil.awvalid = 1'b1; axil.awaddr = 32'h0000_1000;
    axil.wvalid  = 1'b1; axil.wdata  = 32'h0000_0000;
    axil.arvalid = 1'b1; axil.araddr = 32'h0000_1000;
    @(negedge clk);
    axil.awvalid = 1'b0; axil.wvalid = 1'b0; axil.arvalid = 1'b0;
    recv_r("ctrl_pre_write", 32'h0000_0001, RESP_OKAY);
    recv_b("ctrl_race", RESP_OKAY);
    check("ctrl_race_enable_off", 32'(stage_enable), 32'd0);

    // 6: reset with rvalid up and AW latched
    send_ar(32'h0000_0004);
    send_aw(32'h0000_1000);
    check("t6_rvalid_before", 32'(axil.rvalid), 32'd1);
    check("t6_aw_latched", 32'(axil.awready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rvalid_cleared", 32'(axil.rvalid), 32'd0);
    check("t6_bvalid_cleared", 32'(axil.bvalid), 32'd0);
    check("t6_wr_state_idle", 32'(dbg_wr_state), 32'(WR_IDLE));
    check("t6_rd_state_idle", 32'(dbg_rd_state), 32'(RD_IDLE));
    check("t6_wready_in_reset", 32'(axil.wready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_awready_back", 32'(axil.awready), 32'd1);
    check("t6_wready_back", 32'(axil.wready), 32'd1);
    check("t6_bvalid_none", 32'(axil.bvalid), 32'd0);
    read("t6_scratch_reset", 32'h0000_0004, 32'd0, RESP_OKAY);
    fork
      send_aw(32'h0000_0004);
      send_w(32'h55AA_55AA);
    join
    recv_b("t6_after_reset", RESP_OKAY);
    read("t6_scratch_new", 32'h0000_0004, 32'h55AA_55AA, RESP_OKAY);
    read("t6_ctrl_reset", 32'h0000_1000, 32'd0, RESP_OKAY);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // overall time guard
  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
